// File: rtl/game_pkg.sv
// Shared definitions for the two-player game: scheduler states, screen
// geometry, player box size, start positions and a small distance helper.
package game_pkg;

  typedef enum logic [3:0] {
    WAIT     = 4'd0,
    CHK_A    = 4'd1,
    MOVE_A   = 4'd2,
    SETTLE_A = 4'd3,
    CHK_B    = 4'd4,
    MOVE_B   = 4'd5,
    GOAL     = 4'd6,
    HOLD     = 4'd7,
    OVER     = 4'd8
  } state_t;

  // Visible playfield and its inclusive borders (enforced by the movers).
  localparam logic [7:0] SCREEN_W = 8'd160;
  localparam logic [6:0] SCREEN_H = 7'd120;
  localparam logic [7:0] BORDER_L = 8'd0;
  localparam logic [7:0] BORDER_R = 8'd159;
  localparam logic [6:0] BORDER_T = 7'd0;
  localparam logic [6:0] BORDER_B = 7'd119;

  // Side of the square player box in pixels.
  localparam int unsigned PLAYER_SIZE = 5;

  // Positions loaded by the movers while reset_game is asserted.
  localparam logic [7:0] P1_START_X = 8'd20;
  localparam logic [6:0] P1_START_Y = 7'd58;
  localparam logic [7:0] P2_START_X = 8'd135;
  localparam logic [6:0] P2_START_Y = 7'd58;

  // Absolute distance between two widened coordinates.
  function automatic logic [8:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
    logic [8:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

endpackage

// File: rtl/collision_check.sv
// Box-vs-box contact test: for player A against player B, clears the allow
// bit of every direction in which A's box already touches B's box.
// allow = {right, left, up, down}.
module collision_check
  import game_pkg::*;
#(
  parameter int unsigned SIZE = PLAYER_SIZE
) (
  input  logic [7:0] a_x,
  input  logic [6:0] a_y,
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  output logic [3:0] allow
);

  localparam logic [8:0] SIZE9 = 9'(SIZE);

  logic [8:0] ax_s;
  logic [8:0] ay_s;
  logic [8:0] bx_s;
  logic [8:0] by_s;
  logic       ovl_x_s;
  logic       ovl_y_s;

  // Widen coordinates so A+S / B+S cannot wrap at the right/bottom edges.
  always_comb begin
    ax_s    = {1'b0, a_x};
    bx_s    = {1'b0, b_x};
    ay_s    = {2'b00, a_y};
    by_s    = {2'b00, b_y};
    ovl_x_s = (abs_diff9(ax_s, bx_s) < SIZE9);
    ovl_y_s = (abs_diff9(ay_s, by_s) < SIZE9);
    allow   = 4'b1111;
    allow[3] = !((bx_s == (ax_s + SIZE9)) && ovl_y_s);
    allow[2] = !((ax_s == (bx_s + SIZE9)) && ovl_y_s);
    allow[1] = !((ay_s == (by_s + SIZE9)) && ovl_x_s);
    allow[0] = !((by_s == (ay_s + SIZE9)) && ovl_x_s);
  end

endmodule

// File: rtl/move_scheduler.sv
// Frame-level controller: divides the clock into game ticks, grants each
// player one movement strobe per tick with alternating priority, registers
// collision-based allow flags just before each strobe, and runs the
// goal -> hold (reset_game) -> resume sequence with scoring and game over.
module move_scheduler #(
  parameter logic [26:0] TICK_DIV    = 27'd1666666,
  parameter int unsigned PLAYER_SIZE = game_pkg::PLAYER_SIZE,
  parameter logic [7:0]  HOLD_TICKS  = 8'd60,
  parameter logic [3:0]  WIN_SCORE   = 4'd5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] p1_x,
  input  logic [6:0] p1_y,
  input  logic [7:0] p2_x,
  input  logic [6:0] p2_y,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       p1_move_en,
  output logic       p2_move_en,
  output logic [3:0] p1_allow,
  output logic [3:0] p2_allow,
  output logic       reset_game,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over
);

  import game_pkg::*;

  logic [26:0] tick_cnt_r;
  logic        tick_s;

  state_t      state_r;
  logic        first_p1_r;
  logic        pend_p1_r;
  logic        pend_p2_r;
  logic [7:0]  hold_cnt_r;
  logic [3:0]  score_p1_r;
  logic [3:0]  score_p2_r;
  logic        game_over_r;
  logic        reset_game_r;
  logic        p1_en_r;
  logic        p2_en_r;
  logic [3:0]  p1_allow_r;
  logic [3:0]  p2_allow_r;

  logic        chk_p1_s;
  logic [7:0]  a_x_s;
  logic [6:0]  a_y_s;
  logic [7:0]  b_x_s;
  logic [6:0]  b_y_s;
  logic [3:0]  allow_s;

  logic        accept_goal_s;
  logic        inc_p1_s;
  logic        inc_p2_s;
  logic [3:0]  next_p1_s;
  logic [3:0]  next_p2_s;
  logic        win_s;

  // Tick fires for one cycle whenever the free-running divider reaches zero.
  always_comb begin
    tick_s = (tick_cnt_r == 27'd0);
  end

  // Free-running game-tick divider, independent of the scheduler state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_r <= TICK_DIV - 27'd1;
    end else if (tick_s) begin
      tick_cnt_r <= TICK_DIV - 27'd1;
    end else begin
      tick_cnt_r <= tick_cnt_r - 27'd1;
    end
  end

  // Route the player under check to collision port A, the other to port B.
  always_comb begin
    chk_p1_s = first_p1_r;
    if (state_r == CHK_B) begin
      chk_p1_s = !first_p1_r;
    end else begin
      chk_p1_s = first_p1_r;
    end
    if (chk_p1_s) begin
      a_x_s = p1_x;
      a_y_s = p1_y;
      b_x_s = p2_x;
      b_y_s = p2_y;
    end else begin
      a_x_s = p2_x;
      a_y_s = p2_y;
      b_x_s = p1_x;
      b_y_s = p1_y;
    end
  end

  collision_check #(
    .SIZE (PLAYER_SIZE)
  ) u_collision_check (
    .a_x   (a_x_s),
    .a_y   (a_y_s),
    .b_x   (b_x_s),
    .b_y   (b_y_s),
    .allow (allow_s)
  );

  // Goal acceptance and saturating next-score / win detection.
  always_comb begin
    accept_goal_s = (state_r != HOLD) && (state_r != OVER);
    inc_p1_s      = pend_p1_r && (score_p1_r < WIN_SCORE);
    inc_p2_s      = pend_p2_r && (score_p2_r < WIN_SCORE);
    next_p1_s     = score_p1_r + {3'b000, inc_p1_s};
    next_p2_s     = score_p2_r + {3'b000, inc_p2_s};
    win_s         = (inc_p1_s && (next_p1_s == WIN_SCORE)) ||
                    (inc_p2_s && (next_p2_s == WIN_SCORE));
  end

  // Sticky goal latches; GOAL consumes them while still catching a new pulse.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_p1_r <= 1'b0;
      pend_p2_r <= 1'b0;
    end else if (state_r == GOAL) begin
      pend_p1_r <= goal_p1;
      pend_p2_r <= goal_p2;
    end else if (accept_goal_s) begin
      pend_p1_r <= pend_p1_r | goal_p1;
      pend_p2_r <= pend_p2_r | goal_p2;
    end else begin
      pend_p1_r <= pend_p1_r;
      pend_p2_r <= pend_p2_r;
    end
  end

  // Scheduler FSM with all of its outputs registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r      <= WAIT;
      first_p1_r   <= 1'b1;
      hold_cnt_r   <= 8'd0;
      score_p1_r   <= 4'd0;
      score_p2_r   <= 4'd0;
      game_over_r  <= 1'b0;
      reset_game_r <= 1'b1;
      p1_en_r      <= 1'b0;
      p2_en_r      <= 1'b0;
      p1_allow_r   <= 4'b1111;
      p2_allow_r   <= 4'b1111;
    end else begin
      p1_en_r <= 1'b0;
      p2_en_r <= 1'b0;
      case (state_r)
        WAIT: begin
          reset_game_r <= 1'b0;
          if (tick_s) begin
            if (pend_p1_r || pend_p2_r) begin
              state_r <= GOAL;
            end else begin
              state_r <= CHK_A;
            end
          end else begin
            state_r <= WAIT;
          end
        end
        CHK_A: begin
          // Strobe is raised here so it is visible exactly during MOVE_A.
          if (first_p1_r) begin
            p1_allow_r <= allow_s;
            p1_en_r    <= 1'b1;
          end else begin
            p2_allow_r <= allow_s;
            p2_en_r    <= 1'b1;
          end
          state_r <= MOVE_A;
        end
        MOVE_A: begin
          state_r <= SETTLE_A;
        end
        SETTLE_A: begin
          state_r <= CHK_B;
        end
        CHK_B: begin
          if (first_p1_r) begin
            p2_allow_r <= allow_s;
            p2_en_r    <= 1'b1;
          end else begin
            p1_allow_r <= allow_s;
            p1_en_r    <= 1'b1;
          end
          state_r <= MOVE_B;
        end
        MOVE_B: begin
          first_p1_r <= !first_p1_r;
          state_r    <= WAIT;
        end
        GOAL: begin
          score_p1_r   <= next_p1_s;
          score_p2_r   <= next_p2_s;
          hold_cnt_r   <= HOLD_TICKS;
          reset_game_r <= 1'b1;
          if (win_s) begin
            game_over_r <= 1'b1;
            state_r     <= OVER;
          end else begin
            state_r <= HOLD;
          end
        end
        HOLD: begin
          reset_game_r <= 1'b1;
          if (hold_cnt_r == 8'd0) begin
            first_p1_r <= 1'b1;
            state_r    <= WAIT;
          end else if (tick_s) begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        OVER: begin
          reset_game_r <= 1'b1;
          game_over_r  <= 1'b1;
          state_r      <= OVER;
        end
        default: begin
          reset_game_r <= 1'b1;
          state_r      <= WAIT;
        end
      endcase
    end
  end

  assign p1_move_en = p1_en_r;
  assign p2_move_en = p2_en_r;
  assign p1_allow   = p1_allow_r;
  assign p2_allow   = p2_allow_r;
  assign reset_game = reset_game_r;
  assign score_p1   = score_p1_r;
  assign score_p2   = score_p2_r;
  assign game_over  = game_over_r;

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus random
// positions and goals, compared every cycle against an event-level model.
module tb_move_scheduler;

  localparam int TD = 8;
  localparam int HT = 3;
  localparam int WS = 2;
  localparam int S  = 5;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] p1_x = 8'd40;
  logic [6:0] p1_y = 7'd56;
  logic [7:0] p2_x = 8'd100;
  logic [6:0] p2_y = 7'd56;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       p1_move_en, p2_move_en, reset_game, game_over;
  logic [3:0] p1_allow, p2_allow, score_p1, score_p2;

  always #5 clock = ~clock;

  move_scheduler #(
    .TICK_DIV    (27'd8),
    .PLAYER_SIZE (5),
    .HOLD_TICKS  (8'd3),
    .WIN_SCORE   (4'd2)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .p1_x       (p1_x),
    .p1_y       (p1_y),
    .p2_x       (p2_x),
    .p2_y       (p2_y),
    .goal_p1    (goal_p1),
    .goal_p2    (goal_p2),
    .p1_move_en (p1_move_en),
    .p2_move_en (p2_move_en),
    .p1_allow   (p1_allow),
    .p2_allow   (p2_allow),
    .reset_game (reset_game),
    .score_p1   (score_p1),
    .score_p2   (score_p2),
    .game_over  (game_over)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: events are scheduled by absolute cycle number since reset release.
  bit         m_first_p1, m_pend1, m_pend2, m_over, m_holding;
  int         m_s1, m_s2, m_hold_left, m_wait_at, m_busy_until;
  int         m_en1_at, m_en2_at, m_chk1_at, m_chk2_at, m_goal_at;
  logic [3:0] exp_a1, exp_a2;
  logic       exp_rg, exp_go;

  int st_rg_ticks, st_en1, st_en2, st_first;
  int en1_q[$];
  int en2_q[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [3:0] ref_allow(input int ax, input int ay, input int bx, input int by);
    bit ox, oy;
    logic [3:0] r;
    ox = ((ax > bx) ? ax - bx : bx - ax) < S;
    oy = ((ay > by) ? ay - by : by - ay) < S;
    r[3] = !((bx == ax + S) && oy);
    r[2] = !((ax == bx + S) && oy);
    r[1] = !((ay == by + S) && ox);
    r[0] = !((by == ay + S) && ox);
    return r;
  endfunction

  task automatic model_init();
    m_first_p1 = 1'b1; m_pend1 = 1'b0; m_pend2 = 1'b0; m_over = 1'b0; m_holding = 1'b0;
    m_s1 = 0; m_s2 = 0; m_hold_left = 0; m_wait_at = 0; m_busy_until = -1;
    m_en1_at = -1; m_en2_at = -1; m_chk1_at = -1; m_chk2_at = -1; m_goal_at = -1;
    exp_a1 = 4'b1111; exp_a2 = 4'b1111; exp_rg = 1'b1; exp_go = 1'b0;
    en1_q.delete(); en2_q.delete();
  endtask

  task automatic clear_stats();
    st_rg_ticks = 0; st_en1 = 0; st_en2 = 0; st_first = 0;
  endtask

  // Compare the DUT at the falling edge of cycle cyc, then advance the model.
  task automatic cycle_end();
    int  c;
    bit  tick, idle;
    c = cyc;
    tick = ((c % TD) == TD - 1);
    check_val("p1_move_en", 32'(p1_move_en), 32'(c == m_en1_at));
    check_val("p2_move_en", 32'(p2_move_en), 32'(c == m_en2_at));
    check_val("p1_allow", 32'(p1_allow), 32'(exp_a1));
    check_val("p2_allow", 32'(p2_allow), 32'(exp_a2));
    check_val("reset_game", 32'(reset_game), 32'(exp_rg));
    check_val("score_p1", 32'(score_p1), 32'(m_s1));
    check_val("score_p2", 32'(score_p2), 32'(m_s2));
    check_val("game_over", 32'(game_over), 32'(exp_go));
    if (tick && reset_game === 1'b1) st_rg_ticks++;
    if (p1_move_en === 1'b1) begin st_en1++; en1_q.push_back(c); if (st_first == 0) st_first = 1; end
    if (p2_move_en === 1'b1) begin st_en2++; en2_q.push_back(c); if (st_first == 0) st_first = 2; end

    if (m_holding && c >= m_wait_at) m_holding = 1'b0;
    if (c == m_chk1_at) exp_a1 = ref_allow(int'(p1_x), int'(p1_y), int'(p2_x), int'(p2_y));
    if (c == m_chk2_at) exp_a2 = ref_allow(int'(p2_x), int'(p2_y), int'(p1_x), int'(p1_y));
    if (c == m_goal_at) begin
      if (m_pend1) m_s1++;
      if (m_pend2) m_s2++;
      exp_rg = 1'b1;
      if (m_s1 == WS || m_s2 == WS) begin
        m_over = 1'b1; exp_go = 1'b1;
      end else begin
        m_holding = 1'b1; m_hold_left = HT; m_wait_at = 1 << 30;
      end
      m_pend1 = goal_p1; m_pend2 = goal_p2;
    end else begin
      idle = !m_over && !m_holding && (c > m_busy_until);
      if (idle) begin
        exp_rg = 1'b0;
        if (tick) begin
          if (m_pend1 || m_pend2) begin
            m_goal_at = c + 1; m_busy_until = c + 1;
          end else begin
            if (m_first_p1) begin
              m_chk1_at = c + 1; m_en1_at = c + 2; m_chk2_at = c + 4; m_en2_at = c + 5;
            end else begin
              m_chk2_at = c + 1; m_en2_at = c + 2; m_chk1_at = c + 4; m_en1_at = c + 5;
            end
            m_busy_until = c + 5;
            m_first_p1 = !m_first_p1;
          end
        end
      end
      if (m_holding && tick && m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) begin m_wait_at = c + 2; m_first_p1 = 1'b1; end
      end
      if (!m_over && !m_holding) begin
        m_pend1 = m_pend1 | goal_p1;
        m_pend2 = m_pend2 | goal_p2;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      cycle_end();
      @(posedge clock);
      #1;
      cyc++;
    end
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < TD && (cyc % TD) != ph; i++) run(1);
  endtask

  // Called one time unit after a rising edge; asserts reset mid-cycle.
  task automatic do_reset();
    #2;
    resetn = 1'b0;
    #1;
    check_val("rst_p1_en", 32'(p1_move_en), 32'd0);
    check_val("rst_p2_en", 32'(p2_move_en), 32'd0);
    check_val("rst_p1_allow", 32'(p1_allow), 32'hF);
    check_val("rst_p2_allow", 32'(p2_allow), 32'hF);
    check_val("rst_reset_game", 32'(reset_game), 32'd1);
    check_val("rst_score_p1", 32'(score_p1), 32'd0);
    check_val("rst_score_p2", 32'(score_p2), 32'd0);
    check_val("rst_game_over", 32'(game_over), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    cyc = 0;
    model_init();
  endtask

  task automatic rand_pos();
    int dx, dy;
    p1_x = 8'($urandom_range(0, 255));
    p1_y = 7'($urandom_range(0, 127));
    if ($urandom_range(0, 3) == 0) begin
      p2_x = 8'($urandom_range(0, 255));
      p2_y = 7'($urandom_range(0, 127));
    end else begin
      dx = int'($urandom_range(0, 12)) - 6;
      dy = int'($urandom_range(0, 12)) - 6;
      p2_x = 8'(int'(p1_x) + dx);
      p2_y = 7'(int'(p1_y) + dy);
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    do_reset();
    clear_stats();

    // Priority alternation and face contact, one position set per tick.
    p1_x = 8'd40; p1_y = 7'd56; p2_x = 8'd45; p2_y = 7'd58;
    run(14);
    check_val("touch_x_p1", 32'(p1_allow), 32'b0111);
    check_val("touch_x_p2", 32'(p2_allow), 32'b1011);
    p2_x = 8'd46;
    run(8);
    check_val("gap_x_p1", 32'(p1_allow), 32'b1111);
    check_val("gap_x_p2", 32'(p2_allow), 32'b1111);
    p2_x = 8'd42; p2_y = 7'd61;
    run(8);
    check_val("touch_y_p1", 32'(p1_allow), 32'b1110);
    check_val("touch_y_p2", 32'(p2_allow), 32'b1101);
    p2_x = 8'd45;
    run(8);
    check_val("corner_p1", 32'(p1_allow), 32'b1111);
    check_val("corner_p2", 32'(p2_allow), 32'b1111);
    check_val("first_p1_strobe", 32'(en1_q.size() > 0 ? en1_q[0] : -1), 32'd9);
    check_val("first_p2_strobe", 32'(en2_q.size() > 0 ? en2_q[0] : -1), 32'd12);
    check_val("second_p2_strobe", 32'(en2_q.size() > 1 ? en2_q[1] : -1), 32'd17);
    check_val("second_p1_strobe", 32'(en1_q.size() > 1 ? en1_q[1] : -1), 32'd20);

    // Single goal mid-tick: hold period, no strobes, resume with p1 first.
    run_to_phase(5);
    clear_stats();
    goal_p2 = 1'b1; run(1); goal_p2 = 1'b0;
    run(33);
    check_val("hold_score_p2", 32'(score_p2), 32'd1);
    check_val("hold_rg_ticks", 32'(st_rg_ticks), 32'(HT));
    check_val("hold_no_strobe", 32'(st_en1 + st_en2), 32'd0);
    clear_stats();
    run(14);
    check_val("resume_first", 32'(st_first), 32'd1);

    // Simultaneous goals: both score once, a single hold period.
    do_reset();
    run_to_phase(5);
    clear_stats();
    goal_p1 = 1'b1; goal_p2 = 1'b1; run(1); goal_p1 = 1'b0; goal_p2 = 1'b0;
    run(33);
    check_val("dual_score_p1", 32'(score_p1), 32'd1);
    check_val("dual_score_p2", 32'(score_p2), 32'd1);
    check_val("dual_rg_ticks", 32'(st_rg_ticks), 32'(HT));
    check_val("dual_no_strobe", 32'(st_en1 + st_en2), 32'd0);
    run(14);

    // Winning goal: game over is terminal until reset.
    run_to_phase(5);
    goal_p1 = 1'b1; run(1); goal_p1 = 1'b0;
    run(10);
    check_val("win_score_p1", 32'(score_p1), 32'(WS));
    check_val("win_game_over", 32'(game_over), 32'd1);
    clear_stats();
    for (int i = 0; i < 40; i++) begin
      goal_p1 = (i % 7 == 0); goal_p2 = (i % 11 == 3);
      run(1);
    end
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    check_val("over_no_strobe", 32'(st_en1 + st_en2), 32'd0);
    check_val("over_rg_ticks", 32'(st_rg_ticks), 32'd5);
    check_val("over_score_p1", 32'(score_p1), 32'(WS));
    check_val("over_score_p2", 32'(score_p2), 32'd1);

    // Random positions and goals against the model, with periodic resets.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        rand_pos();
        goal_p1 = ($urandom_range(0, 49) == 0);
        goal_p2 = ($urandom_range(0, 49) == 0);
        run(1);
      end
      goal_p1 = 1'b0; goal_p2 = 1'b0;
    end
    do_reset();
    run(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
